// File: rtl/otl_spi_slave_if.sv
// SPI pins plus register-bus strobes of the otl SPI responder.
interface otl_spi_slave_if;
  logic        spi_clk;
  logic        spi_le;
  logic        spi_mosi;
  logic        spi_miso;
  logic        busy;
  logic [6:0]  addr;
  logic [15:0] wr_data;
  logic        wr_strobe;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        frame_err;

  modport slave (
    input  spi_clk, spi_le, spi_mosi, rd_data,
    output spi_miso, busy, addr, wr_data, wr_strobe, rd_req, frame_err
  );

  modport master (
    output spi_clk, spi_le, spi_mosi, rd_data,
    input  spi_miso, busy, addr, wr_data, wr_strobe, rd_req, frame_err
  );
endinterface

// File: rtl/otl_spi_slave.sv
// Oversampling SPI responder for the 24-bit otl frame: flag, 7-bit addr, 16-bit data.
// Read frames return one byte on MISO during the last 8 bit times.
module otl_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic            sys_clk,
  input logic            reset,
  otl_spi_slave_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync, le_sync, mosi_sync;
  logic                   clk_d, le_d;
  logic                   clk_s, le_s, mosi_s;
  logic                   clk_rise, clk_fall, le_rise, le_fall;
  logic [4:0]             bit_cnt;
  logic [23:0]            rx_sr, rx_nxt;
  logic [7:0]             tx_sr;
  logic                   rd_ld;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign le_s     = le_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;
  assign le_rise  = le_s & ~le_d;
  assign le_fall  = ~le_s & le_d;
  assign rx_nxt   = {rx_sr[22:0], mosi_s};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clk_sync      <= '0;
      le_sync       <= '0;
      mosi_sync     <= '0;
      clk_d         <= 1'b0;
      le_d          <= 1'b0;
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      rd_ld         <= 1'b0;
      bus.spi_miso  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.addr      <= '0;
      bus.wr_data   <= '0;
      bus.wr_strobe <= 1'b0;
      bus.rd_req    <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      clk_sync      <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      le_sync       <= {le_sync[SYNC_STAGES-2:0], bus.spi_le};
      mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      clk_d         <= clk_s;
      le_d          <= le_s;
      bus.wr_strobe <= 1'b0;
      bus.rd_req    <= 1'b0;
      bus.frame_err <= 1'b0;
      // user read byte is captured the cycle after the request pulse
      rd_ld         <= bus.rd_req;
      if (rd_ld) tx_sr <= bus.rd_data;

      case (state)
        IDLE: begin
          bus.spi_miso <= 1'b0;
          bus.busy     <= 1'b0;
          if (le_fall) begin
            state    <= SHIFT;
            bus.busy <= 1'b1;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
          end
        end
        SHIFT: begin
          // frame end wins over any SPI clock edge seen in the same cycle
          if (le_rise) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.spi_miso <= 1'b0;
            if (bit_cnt == 5'd24) begin
              if (rx_sr[23]) begin
                bus.wr_data   <= rx_sr[15:0];
                bus.wr_strobe <= 1'b1;
              end
            end else begin
              bus.frame_err <= 1'b1;
            end
          end else begin
            if (clk_rise) begin
              rx_sr <= rx_nxt;
              if (bit_cnt != 5'd25) bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bus.addr <= rx_nxt[6:0];
                if (!rx_nxt[7]) bus.rd_req <= 1'b1;
                else            tx_sr      <= '0;
              end
            end
            if (clk_fall) begin
              if (bit_cnt >= 5'd16 && bit_cnt <= 5'd23) begin
                bus.spi_miso <= tx_sr[7];
                tx_sr        <= {tx_sr[6:0], 1'b0};
              end else begin
                bus.spi_miso <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_otl_spi_slave.sv
// Bench for otl_spi_slave: directed and random SPI frames against a frame-level reference model.
module tb_otl_spi_slave;
  localparam int SYNC = 2;

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  otl_spi_slave_if bus();
  otl_spi_slave #(.SYNC_STAGES(SYNC)) dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor; also plays the register-file user answering rd_req.
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, ovl_cnt = 0, idle_miso = 0;
  logic [6:0]  rd_addr_seen = '0;
  logic [7:0]  rd_mem [128];

  always @(negedge sys_clk) begin
    if (bus.wr_strobe) wr_cnt++;
    if (bus.rd_req) begin
      rd_cnt++;
      rd_addr_seen = bus.addr;
      bus.rd_data  = rd_mem[bus.addr];
    end
    if (bus.frame_err) err_cnt++;
    if (int'(bus.wr_strobe) + int'(bus.rd_req) + int'(bus.frame_err) > 1) ovl_cnt++;
    if (!bus.busy && bus.spi_miso) idle_miso++;
  end

  int         hp = 8;
  logic [7:0] miso_byte;
  logic       busy_mid;

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // SPI master: nbits rising edges, optional le-rise coincident with the last fall,
  // optional reset after rising edge abort_at (le stays low through reset).
  task automatic frame(input logic [23:0] w, input int nbits, input bit coinc, input int abort_at);
    miso_byte  = '0;
    busy_mid   = 1'b0;
    bus.spi_le = 1'b0;
    cyc(hp);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = (i < 24) ? w[23-i] : 1'($urandom);
      cyc(hp);
      bus.spi_clk = 1'b1;
      if (i >= 16 && i < 24) miso_byte = {miso_byte[6:0], bus.spi_miso};
      if (i == 11) busy_mid = bus.busy;
      cyc(hp);
      bus.spi_clk = 1'b0;
      if (abort_at != 0 && i + 1 == abort_at) begin
        cyc(2);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(4 * hp);
        bus.spi_le = 1'b1;
        cyc(4 * hp);
        return;
      end
      if (i == nbits - 1) begin
        if (coinc) bus.spi_le = 1'b1;
        else begin
          cyc(hp);
          bus.spi_le = 1'b1;
        end
      end
    end
    cyc(4 * hp);
  endtask

  // Reference: 24 bits + flag -> one write; flag clear with >=8 bits -> one read request;
  // any count other than 24 -> one frame error; full read frames return rd_mem[addr] on MISO.
  task automatic run_frame(input string nm, input logic [23:0] w, input int nbits, input bit coinc);
    int  w0, r0, e0;
    bit  flag, full;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    flag = w[23];
    full = (nbits == 24);
    frame(w, nbits, coinc, 0);
    chk({nm, " wr_strobe count"}, 32'(wr_cnt - w0), 32'(full && flag));
    chk({nm, " rd_req count"}, 32'(rd_cnt - r0), 32'(!flag && nbits >= 8));
    chk({nm, " frame_err count"}, 32'(err_cnt - e0), 32'(!full));
    chk({nm, " busy after"}, 32'(bus.busy), 32'd0);
    if (nbits >= 12) chk({nm, " busy mid"}, 32'(busy_mid), 32'd1);
    chk({nm, " addr"}, 32'(bus.addr), 32'(w[22:16]));
    if (full && flag) chk({nm, " wr_data"}, 32'(bus.wr_data), 32'(w[15:0]));
    if (!flag) chk({nm, " rd_req addr"}, 32'(rd_addr_seen), 32'(w[22:16]));
    if (nbits >= 24) chk({nm, " miso byte"}, 32'(miso_byte), flag ? 32'd0 : 32'(rd_mem[w[22:16]]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int w0, r0, e0, nb;
    for (int i = 0; i < 128; i++) rd_mem[i] = 8'($urandom);
    rd_mem[5] = 8'hC3;
    bus.spi_clk  = 1'b0;
    bus.spi_le   = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.rd_data  = '0;
    reset        = 1'b1;
    cyc(4);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset miso", 32'(bus.spi_miso), 32'd0);
    chk("reset addr", 32'(bus.addr), 32'd0);
    chk("reset wr_data", 32'(bus.wr_data), 32'd0);
    chk("reset pulses", 32'({bus.wr_strobe, bus.rd_req, bus.frame_err}), 32'd0);
    reset = 1'b0;
    cyc(20);
    chk("le low through reset no frame", 32'(bus.busy), 32'd0);
    bus.spi_le = 1'b1;
    cyc(20);

    hp = 8;
    run_frame("write A55A", {1'b1, 7'h00, 16'hA55A}, 24, 1'b0);
    run_frame("read 05", {1'b0, 7'h05, 16'h0000}, 24, 1'b0);
    run_frame("short 20", {1'b1, 7'h11, 16'h5555}, 20, 1'b0);
    run_frame("write 1234", {1'b1, 7'h22, 16'h1234}, 24, 1'b0);
    run_frame("long 26", {1'b1, 7'h33, 16'h7777}, 26, 1'b0);

    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    frame({1'b1, 7'h44, 16'hDEAD}, 24, 1'b0, 10);
    chk("abort pulses", 32'((wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0)), 32'd0);
    chk("abort wr_data", 32'(bus.wr_data), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    run_frame("write BEEF", {1'b1, 7'h44, 16'hBEEF}, 24, 1'b0);

    run_frame("coinc write", {1'b1, 7'h55, 16'h0F0F}, 24, 1'b1);
    run_frame("coinc read", {1'b0, 7'h66, 16'hFFFF}, 24, 1'b1);

    for (int k = 0; k < 20; k++) begin
      hp = $urandom_range(SYNC + 2, 10);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 26) : 24;
      run_frame($sformatf("rand%0d", k), 24'($urandom), nb, 1'($urandom));
    end

    chk("pulse overlap cycles", 32'(ovl_cnt), 32'd0);
    chk("miso high while idle", 32'(idle_miso), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
